// File: rtl/argmax_sequencer_if.sv
// Score-buffer read port and result handshake of the argmax sequencer.
// Optional runner-up outputs exist only when ARGMAX_RUNNER_UP_EN is defined.
interface argmax_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 4
) ();
  logic                     start;
  logic                     busy;
  logic                     rd_en;
  logic        [IDX_W-1:0]  rd_addr;
  logic signed [DATA_W-1:0] rd_data;
  logic                     res_valid;
  logic                     res_ready;
  logic        [IDX_W-1:0]  res_idx;
  logic signed [DATA_W-1:0] res_score;
`ifdef ARGMAX_RUNNER_UP_EN
  logic        [IDX_W-1:0]  res_idx2;
  logic signed [DATA_W-1:0] res_score2;
`endif

  // Sequencer side
  modport master (
`ifdef ARGMAX_RUNNER_UP_EN
    output res_idx2,
    output res_score2,
`endif
    input  start,
    output busy,
    output rd_en,
    output rd_addr,
    input  rd_data,
    output res_valid,
    input  res_ready,
    output res_idx,
    output res_score
  );

  // Score buffer / result consumer side
  modport slave (
`ifdef ARGMAX_RUNNER_UP_EN
    input  res_idx2,
    input  res_score2,
`endif
    output start,
    input  busy,
    input  rd_en,
    input  rd_addr,
    output rd_data,
    input  res_valid,
    output res_ready,
    input  res_idx,
    input  res_score
  );
endinterface

// File: rtl/argmax_sequencer.sv
// Argmax sequencer: reads NUM_CLASS signed scores from the output-layer
// score buffer, tracks the running maximum (lowest index wins on ties) and
// presents the winning index/score through a valid/ready handshake.
// Optional feature macro: ARGMAX_RUNNER_UP_EN adds the second-best
// index/score outputs (res_idx2/res_score2).
module argmax_sequencer #(
  parameter int DATA_W    = 16,
  parameter int NUM_CLASS = 10,
  parameter int IDX_W     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  argmax_sequencer_if.master bus
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  localparam logic        [IDX_W-1:0]  LAST_ADDR = IDX_W'(NUM_CLASS - 1);
  localparam logic signed [DATA_W-1:0] MOST_NEG  = {1'b1, {(DATA_W-1){1'b0}}};

  // Strict signed greater-than; strictness is what makes the lowest index win ties.
  function automatic logic gt_s(input logic signed [DATA_W-1:0] a,
                                input logic signed [DATA_W-1:0] b);
    return a > b;
  endfunction

  state_t                   state, state_nxt;
  logic        [IDX_W-1:0]  cnt, cnt_nxt;
  logic                     vld_p1;
  logic        [IDX_W-1:0]  addr_p1;
  logic signed [DATA_W-1:0] rd_data_p1;
  logic signed [DATA_W-1:0] max_p2;
  logic        [IDX_W-1:0]  idx_p2;
`ifdef ARGMAX_RUNNER_UP_EN
  logic signed [DATA_W-1:0] max2_p2;
  logic        [IDX_W-1:0]  idx2_p2;
`endif

  assign rd_data_p1 = bus.rd_data;

  // FSM state and read-address counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic; the counter is parked at 0 outside READ so rd_addr idles at 0
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (bus.start) state_nxt = READ;
      end
      READ: begin
        if (cnt == LAST_ADDR) begin
          state_nxt = DRAIN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DRAIN: state_nxt = DONE;
      DONE: begin
        if (bus.res_ready) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // ---- stage p0: address issue ----
  assign bus.busy      = (state != IDLE);
  assign bus.rd_en     = (state == READ);
  assign bus.rd_addr   = cnt;
  assign bus.res_valid = (state == DONE);

  // Delay the read strobe and address to line up with the buffer's 1-cycle read data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      addr_p1 <= '0;
    end else begin
      vld_p1  <= bus.rd_en;
      addr_p1 <= cnt;
    end
  end

  // ---- stage p1 -> p2: running max / runner-up update ----
  // Running maximum tracker; sample 0 seeds it unconditionally
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      max_p2  <= '0;
      idx_p2  <= '0;
`ifdef ARGMAX_RUNNER_UP_EN
      max2_p2 <= '0;
      idx2_p2 <= '0;
`endif
    end else if (vld_p1) begin
      if (addr_p1 == '0) begin
        max_p2  <= rd_data_p1;
        idx_p2  <= '0;
`ifdef ARGMAX_RUNNER_UP_EN
        max2_p2 <= MOST_NEG;
        idx2_p2 <= '0;
`endif
      end else if (gt_s(rd_data_p1, max_p2)) begin
        max_p2  <= rd_data_p1;
        idx_p2  <= addr_p1;
`ifdef ARGMAX_RUNNER_UP_EN
        max2_p2 <= max_p2;
        idx2_p2 <= idx_p2;
`endif
      end
`ifdef ARGMAX_RUNNER_UP_EN
      else if (gt_s(rd_data_p1, max2_p2)) begin
        max2_p2 <= rd_data_p1;
        idx2_p2 <= addr_p1;
      end
`endif
    end
  end

  assign bus.res_idx    = idx_p2;
  assign bus.res_score  = max_p2;
`ifdef ARGMAX_RUNNER_UP_EN
  assign bus.res_idx2   = idx2_p2;
  assign bus.res_score2 = max2_p2;
`endif

endmodule

// File: doc/argmax_sequencer.md
Name: argmax_sequencer

Overview:
- Controller that sequences the final classification step of the CNN.
- On `start`, it reads NUM_CLASS signed class scores from the output-layer score buffer, one address per cycle.
- Keeps a running maximum and its index, then presents the winning class index and score with a valid/ready handshake.
- Sits between the last fully-connected layer's score buffer and the result/UART reporting logic.

Parameters:
- DATA_W, 16, score width; two's-complement signed.
- NUM_CLASS, 10, number of class scores read per classification; legal range 2..(2^IDX_W).
- IDX_W, 4, width of class index and buffer address.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  single-cycle request to begin a classification; honoured only in IDLE.
- busy  out  1  high from the cycle after an accepted start until the result handshake completes.
- rd_en  out  1  score buffer read strobe.
- rd_addr  out  IDX_W  score buffer read address.
- rd_data  in  DATA_W  score buffer read data; valid exactly 1 cycle after rd_en.
- res_valid  out  1  result available; held until accepted.
- res_ready  in  1  downstream accepts the result when res_valid and res_ready are both high.
- res_idx  out  IDX_W  winning class index, 0-based.
- res_score  out  DATA_W  winning score.

Behaviour:
- Reset: applied on the rising edge while rst_n=0, from any state.
  - State returns to IDLE.
  - busy, rd_en, res_valid are 0; rd_addr, res_idx, res_score are 0.
  - Internal max/index/counters are cleared.
  - Reset mid-read abandons the classification; no result is produced.
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE:
  - start=1 moves to READ next cycle.
  - start in any other state is ignored and not queued.
- READ:
  - rd_en=1 each cycle, with rd_addr = 0, 1, ..., NUM_CLASS-1 on consecutive cycles.
  - After the cycle issuing addr NUM_CLASS-1, go to DRAIN.
- DRAIN: rd_en=0 for one cycle while the last rd_data is consumed; then go to DONE.
- Data capture:
  - An internal rd_en delayed by 1 cycle qualifies rd_data.
  - The first qualified sample (addr 0) loads max=rd_data, idx=0 unconditionally.
  - Each later sample replaces max/idx only if rd_data > max under a signed compare.
- Ties: strict greater-than, so the lowest index among equal maxima wins.
- DONE:
  - res_valid=1; res_idx/res_score are stable and equal the final max/idx.
  - On res_valid & res_ready, go to IDLE next cycle; res_valid and busy drop that cycle.
  - res_ready while not in DONE has no effect.
- Latency: start accepted at cycle t.
  - addr 0 is issued at t+1 and addr NUM_CLASS-1 at t+NUM_CLASS.
  - Last data arrives at t+NUM_CLASS+1 (DRAIN).
  - res_valid is high from t+NUM_CLASS+2.
- Back-to-back: a start in the same cycle as the result handshake is ignored. A start the cycle after (IDLE) is accepted.
- res_idx/res_score retain the last result after leaving DONE; they only change during the next classification.
- Widths:
  - Compare is DATA_W-bit signed.
  - Counters are IDX_W bits and never wrap, because NUM_CLASS ≤ 2^IDX_W and the count terminates at NUM_CLASS-1.

Optional Feature:
- Macro ARGMAX_RUNNER_UP_EN.
- Defined:
  - Adds outputs res_idx2 (IDX_W) and res_score2 (DATA_W), giving the second-highest score and its index.
  - When a new max is found, the old max/idx move into the runner-up slot.
  - Otherwise, rd_data > runner-up (signed, strict) replaces the runner-up.
  - Sample 0 initialises runner-up to the most negative value, idx 0.
  - Ties keep the lower index.
  - Reset value is 0, and the outputs are held with res_valid like the primary result.
- Undefined: those ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- NUM_CLASS=4, scores {5,−3,12,7}, start at t=0 -> rd_addr 0..3 at t=1..4, res_valid at t=6, res_idx=2, res_score=12.
- Signed check, scores {−1,−8,−2,−100} -> res_idx=0, res_score=0xFFFF (−1); scores {0x7FFF,0x8000,0,1} -> idx 0.
- Tie, scores {9,9,4,9} -> res_idx=0; with ARGMAX_RUNNER_UP_EN: res_idx2=1, res_score2=9.
- Backpressure: hold res_ready=0 for 5 cycles in DONE -> res_valid, res_idx, res_score stable; start pulses during busy are ignored (no rd_en); res_ready=1 -> IDLE next cycle, busy=0.
- Reset mid-operation: rst_n=0 at cycle t+2 of READ -> next edge rd_en=0, busy=0, res_valid=0; a new start then gives the correct result for new scores {1,2,3,4} -> idx 3.
- NUM_CLASS=10, random scores over 200 classifications with random res_ready stalls -> res_idx/res_score match the reference model (signed argmax, lowest index on tie).
